// File: rtl/mat_vec_loader.sv
// Job loader for the 8x8 matrix-vector MAC: fetches eight matrix rows plus the
// vector over Avalon-MM, then streams them column-wise into the A/B FIFOs.
module mat_vec_loader #(
   parameter int          DATA_WIDTH = 8,
   parameter int          DEPTH      = 8,
   parameter int          ADDR_WIDTH = 32,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        mac_clr,
   output logic [ADDR_WIDTH-1:0]       mem_address,
   output logic                        mem_read,
   input  logic                        mem_waitrequest,
   input  logic [DATA_WIDTH*DEPTH-1:0] mem_readdata,
   input  logic                        mem_readdatavalid,
   output logic                        a_wren,
   output logic [DATA_WIDTH-1:0]       a_fifo_in [DEPTH-1:0],
   output logic                        b_wren,
   output logic [DATA_WIDTH-1:0]       b_fifo_in
);

   localparam int WORD_W = DATA_WIDTH * DEPTH;
   localparam int IW     = $clog2(DEPTH + 1);
   localparam int CW     = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_PUSH = 2'd3;

   logic [1:0]        state_reg, state_next;
   logic [IW-1:0]     word_idx_reg, word_idx_next;
   logic [CW-1:0]     col_reg, col_next;
   logic              done_reg, done_next;
   logic              mac_clr_reg, mac_clr_next;
   logic              capture;
   logic [WORD_W-1:0] buf_reg [DEPTH:0];

   always_comb begin
      state_next    = state_reg;
      word_idx_next = word_idx_reg;
      col_next      = col_reg;
      done_next     = done_reg;
      mac_clr_next  = 1'b0;
      capture       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next    = S_READ;
               word_idx_next = '0;
               mac_clr_next  = 1'b1;
               done_next     = 1'b0;
            end
         end
         S_READ: begin
            if (!mem_waitrequest) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem_readdatavalid) begin
               capture = 1'b1;
               if (word_idx_reg == IW'(DEPTH)) begin
                  state_next = S_PUSH;
                  col_next   = '0;
               end else begin
                  word_idx_next = word_idx_reg + 1'b1;
                  state_next    = S_READ;
               end
            end
         end
         S_PUSH: begin
            if (col_reg == CW'(DEPTH - 1)) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end else begin
               col_next = col_reg + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         word_idx_reg <= '0;
         col_reg      <= '0;
         done_reg     <= 1'b0;
         mac_clr_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         word_idx_reg <= word_idx_next;
         col_reg      <= col_next;
         done_reg     <= done_next;
         mac_clr_reg  <= mac_clr_next;
      end
   end

   // Entries 0..DEPTH-1 hold matrix rows, entry DEPTH holds the vector.
   generate
      for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_buf
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               buf_reg[gi] <= '0;
            else if (capture && word_idx_reg == IW'(gi))
               buf_reg[gi] <= mem_readdata;
         end
      end
   endgenerate

   assign busy        = (state_reg != S_IDLE);
   assign done        = done_reg;
   assign mac_clr     = mac_clr_reg;
   assign mem_read    = (state_reg == S_READ);
   assign mem_address = BASE + ADDR_WIDTH'(word_idx_reg);
   assign a_wren      = (state_reg == S_PUSH);
   assign b_wren      = (state_reg == S_PUSH);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
         assign a_fifo_in[gi] = a_wren ? buf_reg[gi][col_reg*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
   endgenerate

   assign b_fifo_in = b_wren ? buf_reg[DEPTH][col_reg*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_mat_vec_loader.sv
// Bench for mat_vec_loader: Avalon-MM memory responder with stall/latency
// injection, push monitor, and a job-level reference built from memory contents.
module tb_mat_vec_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, mac_clr;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_waitrequest = 1'b0;
   logic [63:0] mem_readdata = '0;
   logic        mem_readdatavalid = 1'b0;
   logic        a_wren, b_wren;
   logic [7:0]  a_fifo_in [7:0];
   logic [7:0]  b_fifo_in;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] mem [0:15];
   int          wait_addr = 99, wait_n = 0, v_addr = 99, v_delay = 0;
   bit          clr_req = 1'b0;

   // responder state
   bit          pend = 1'b0, req_new = 1'b1;
   int          wl = 0, pdelay = 0;
   logic [31:0] paddr = '0;
   int          reads_q[$];

   // monitor state
   int           busy_cnt = 0, mac_clr_cnt = 0, done_rise = 0, stray = 0;
   bit           prev_done = 1'b0;
   logic [71:0]  push_q[$];
   logic [63:0]  ap;

   mat_vec_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .mac_clr(mac_clr),
      .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .a_wren(a_wren), .a_fifo_in(a_fifo_in), .b_wren(b_wren), .b_fifo_in(b_fifo_in)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pack_a();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = a_fifo_in[i];
      return v;
   endfunction

   // Memory slave: one stall window on wait_addr, extra data latency on v_addr.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0; req_new = 1'b1; wl = 0;
         mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
      end else begin
         if (clr_req) reads_q.delete();
         mem_readdatavalid = 1'b0;
         mem_readdata = {$urandom, $urandom};
         if (pend) begin
            if (pdelay == 0) begin
               mem_readdatavalid = 1'b1;
               mem_readdata = mem[paddr[3:0]];
               pend = 1'b0;
            end else pdelay--;
         end
         if (mem_read) begin
            if (req_new) begin
               wl = (mem_address == wait_addr) ? wait_n : 0;
               req_new = 1'b0;
            end
            if (wl > 0) begin
               mem_waitrequest = 1'b1;
               wl--;
            end else begin
               mem_waitrequest = 1'b0;
               pend = 1'b1;
               paddr = mem_address;
               pdelay = (mem_address == v_addr) ? v_delay : 0;
               reads_q.push_back(int'(mem_address));
               req_new = 1'b1;
            end
         end else mem_waitrequest = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (clr_req) begin
         busy_cnt = 0; mac_clr_cnt = 0; done_rise = 0; stray = 0;
         push_q.delete();
      end else if (rst_n) begin
         if (busy) busy_cnt++;
         if (mac_clr) mac_clr_cnt++;
         if (done && !prev_done) done_rise++;
         ap = pack_a();
         if (a_wren != b_wren) stray++;
         if (a_wren) push_q.push_back({b_fifo_in, ap});
         else if (ap != 0 || b_fifo_in != 0) stray++;
      end
      prev_done = done;
   end

   task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic setup_and_start(input int wa, input int wn, input int va, input int vd);
      tick();
      wait_addr = wa; wait_n = wn; v_addr = va; v_delay = vd;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_job(input string name, input int wa, input int wn, input int va,
                          input int vd, input bit extra);
      int k;
      int exp_busy;
      logic [63:0] ea;
      setup_and_start(wa, wn, va, vd);
      k = 0;
      while (!(done && !busy) && k < 300) begin
         tick();
         k++;
         start = extra && (k == 4 || k == 22);
      end
      start = 1'b0;
      check_val({name, " timeout"}, (k < 300), 1);
      tick();
      exp_busy = 26 + ((wa >= 0 && wa <= 8) ? wn : 0) + ((va >= 0 && va <= 8) ? vd : 0);
      check_val({name, " nreads"}, reads_q.size(), 9);
      for (int i = 0; i < reads_q.size() && i < 9; i++)
         check_val($sformatf("%s addr%0d", name, i), reads_q[i], i);
      check_val({name, " npush"}, push_q.size(), 8);
      for (int j = 0; j < push_q.size() && j < 8; j++) begin
         for (int i = 0; i < 8; i++) ea[8*i +: 8] = mem[i][8*j +: 8];
         check_val($sformatf("%s col%0d", name, j), push_q[j], {mem[8][8*j +: 8], ea});
      end
      check_val({name, " busy_cycles"}, busy_cnt, exp_busy);
      check_val({name, " mac_clr"}, mac_clr_cnt, 1);
      check_val({name, " done_rise"}, done_rise, 1);
      check_val({name, " done"}, done, 1);
      check_val({name, " stray"}, stray, 0);
      $display("job %s: reads=%0d pushes=%0d busy=%0d", name, reads_q.size(), push_q.size(), busy_cnt);
   endtask

   task automatic check_idle_outputs(input string name);
      check_val({name, " busy"}, busy, 0);
      check_val({name, " done"}, done, 0);
      check_val({name, " mac_clr"}, mac_clr, 0);
      check_val({name, " mem_read"}, mem_read, 0);
      check_val({name, " a_wren"}, a_wren, 0);
      check_val({name, " b_wren"}, b_wren, 0);
      check_val({name, " a_data"}, pack_a(), 0);
      check_val({name, " b_data"}, b_fifo_in, 0);
      check_val({name, " addr"}, mem_address, 0);
   endtask

   initial begin
      int k;
      int acc;
      for (int w = 0; w < 16; w++)
         for (int j = 0; j < 8; j++) mem[w][8*j +: 8] = 8'(8*w + j);

      tick(); tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;

      run_job("basic", 99, 0, 99, 0, 1'b0);
      run_job("wait_w4", 4, 3, 99, 0, 1'b0);
      run_job("vdelay_w8", 99, 0, 8, 5, 1'b0);
      run_job("start_busy", 99, 0, 99, 0, 1'b1);

      // Asynchronous reset while column 3 is on the FIFO inputs.
      setup_and_start(99, 0, 99, 0);
      k = 0;
      while (push_q.size() != 4 && k < 100) begin
         tick();
         k++;
      end
      check_val("rst_mid wait", (k < 100), 1);
      check_val("rst_mid pushing", a_wren, 1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      tick(); tick();
      rst_n = 1'b1;
      run_job("after_rst", 99, 0, 99, 0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 9; w++) mem[w] = {$urandom, $urandom};
         run_job($sformatf("rand%0d", r), $urandom_range(0, 10), $urandom_range(0, 3),
                 $urandom_range(0, 8), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end

      // Matrix of 2s times vector of 3s: each row dot product is 48.
      for (int w = 0; w < 8; w++) mem[w] = {8{8'd2}};
      mem[8] = {8{8'd3}};
      run_job("mac", 99, 0, 99, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         acc = 0;
         foreach (push_q[j]) acc += int'(push_q[j][8*i +: 8]) * int'(push_q[j][71:64]);
         check_val($sformatf("mac out%0d", i), acc, 48);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
